// File: rtl/snn_spike_emitter_pkg.sv
// Shared SNN types: packed coordinates, output spike events, emitter FSM
// states and the threshold compare used at the end of each timestep.
package snn_spike_emitter_pkg;

  localparam int unsigned VEC_COORD_BITS  = 8;
  localparam int unsigned MAX_CHANNELS    = 8;
  localparam int unsigned MAX_NEURON_BITS = 32;
  localparam int unsigned EVT_CH_W        = $clog2(MAX_CHANNELS);
  localparam int          DEFAULT_THRESHOLD = 64;

  typedef struct packed {
    logic [VEC_COORD_BITS-1:0] x;
    logic [VEC_COORD_BITS-1:0] y;
  } vec2_t;

  typedef struct packed {
    vec2_t               coord;
    logic [EVT_CH_W-1:0] channel;
  } spike_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_EMIT,
    ST_DONE
  } emit_state_e;

  function automatic vec2_t pack_coord(input logic [VEC_COORD_BITS-1:0] x,
                                       input logic [VEC_COORD_BITS-1:0] y);
    vec2_t v;
    v.x = x;
    v.y = y;
    return v;
  endfunction

  // Potentials and threshold are both sign-extended from neuron_bits, so the
  // compare behaves exactly like a signed compare at the neuron width.
  function automatic logic [MAX_CHANNELS-1:0] fire_mask(
    input logic [MAX_CHANNELS*MAX_NEURON_BITS-1:0] word,
    input int unsigned                             neuron_bits,
    input int unsigned                             channels,
    input int                                      threshold
  );
    logic [MAX_CHANNELS-1:0]           mask;
    logic [MAX_NEURON_BITS-1:0]        raw;
    logic signed [MAX_NEURON_BITS-1:0] pot;
    logic signed [MAX_NEURON_BITS-1:0] thr;
    int unsigned                       sh;
    mask = '0;
    sh   = MAX_NEURON_BITS - neuron_bits;
    thr  = $signed(MAX_NEURON_BITS'(threshold) << sh) >>> sh;
    for (int unsigned c = 0; c < MAX_CHANNELS; c++) begin
      raw = MAX_NEURON_BITS'(word >> (c * neuron_bits));
      pot = $signed(raw << sh) >>> sh;
      mask[EVT_CH_W'(c)] = (c < channels) && (pot >= thr);
    end
    return mask;
  endfunction

endpackage

// File: rtl/snn_spike_emitter.sv
// End-of-timestep scan of the membrane-potential map: fires neurons at or
// above threshold, zeroes them in place and emits one event per spike.
module snn_spike_emitter
  import snn_spike_emitter_pkg::*;
#(
  parameter int unsigned COORD_BITS  = 8,
  parameter int unsigned IMG_WIDTH   = 32,
  parameter int unsigned IMG_HEIGHT  = 32,
  parameter int unsigned NEURON_BITS = 9,
  parameter int unsigned CHANNELS    = 2,
  parameter int          THRESHOLD   = DEFAULT_THRESHOLD,
  localparam int unsigned ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned WORD_W = CHANNELS * NEURON_BITS,
  localparam int unsigned EVT_W  = 2 * COORD_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fm_rd_en_o,
  output logic [ADDR_W-1:0] fm_rd_addr_o,
  input  logic [WORD_W-1:0] fm_rd_data_i,
  output logic              fm_wr_en_o,
  output logic [ADDR_W-1:0] fm_wr_addr_o,
  output logic [WORD_W-1:0] fm_wr_data_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [EVT_W-1:0]  evt_coord_o,
  output logic [CH_W-1:0]   evt_channel_o
);

  localparam int unsigned X_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  emit_state_e         state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [CHANNELS-1:0] mask_q, mask_d;

  logic [CHANNELS-1:0] fire_c;
  logic [CHANNELS-1:0] lowbit;
  logic [CH_W-1:0]     low_idx;
  logic [ADDR_W-1:0]   pix_addr;
  logic [WORD_W-1:0]   wr_word;
  logic                last_pix;
  logic                x_wrap;
  logic                advance;
  spike_event_t        evt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mask_q  <= mask_d;
    end
  end

  // Datapath: fire mask of the word being evaluated, write-back word and
  // the lowest pending channel of the registered mask.
  always_comb begin
    fire_c   = CHANNELS'(fire_mask((MAX_CHANNELS * MAX_NEURON_BITS)'(fm_rd_data_i),
                                   NEURON_BITS, CHANNELS, THRESHOLD));
    pix_addr = ADDR_W'(y_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x_q);
    x_wrap   = (x_q == X_W'(IMG_WIDTH - 1));
    last_pix = x_wrap && (y_q == Y_W'(IMG_HEIGHT - 1));
    lowbit   = mask_q & (~mask_q + CHANNELS'(1));
    low_idx  = '0;
    wr_word  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (lowbit[c]) low_idx = CH_W'(c);
      wr_word[c*NEURON_BITS +: NEURON_BITS] =
        fire_c[c] ? '0 : fm_rd_data_i[c*NEURON_BITS +: NEURON_BITS];
    end
    evt.coord   = pack_coord(VEC_COORD_BITS'(x_q), VEC_COORD_BITS'(y_q));
    evt.channel = EVT_CH_W'(low_idx);
  end

  // Next-state, pixel counters and pending-spike mask
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mask_d  = mask_q;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_READ: state_d = ST_EVAL;
      ST_EVAL: begin
        if (|fire_c) begin
          mask_d  = fire_c;
          state_d = ST_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        if (evt_ready_i) begin
          mask_d  = mask_q & ~lowbit;
          advance = (mask_d == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      if (last_pix) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_READ;
        if (x_wrap) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
    end
  end

  // Output decode
  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    done_o        = 1'b0;
    fm_rd_en_o    = 1'b0;
    fm_rd_addr_o  = '0;
    fm_wr_en_o    = 1'b0;
    fm_wr_addr_o  = '0;
    fm_wr_data_o  = '0;
    evt_valid_o   = 1'b0;
    evt_coord_o   = '0;
    evt_channel_o = '0;
    unique case (state_q)
      ST_READ: begin
        fm_rd_en_o   = 1'b1;
        fm_rd_addr_o = pix_addr;
      end
      ST_EVAL: begin
        if (|fire_c) begin
          fm_wr_en_o   = 1'b1;
          fm_wr_addr_o = pix_addr;
          fm_wr_data_o = wr_word;
        end
      end
      ST_EMIT: begin
        evt_valid_o   = 1'b1;
        evt_coord_o   = EVT_W'(evt.coord);
        evt_channel_o = CH_W'(evt.channel);
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snn_spike_emitter.sv
// Directed bench for snn_spike_emitter with a 1-cycle-latency feature-map
// model that logs write-backs and events (writes are not applied to memory).
module tb_snn_spike_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        fm_rd_en_o;
  logic [9:0]  fm_rd_addr_o;
  logic [17:0] fm_rd_data_i;
  logic        fm_wr_en_o;
  logic [9:0]  fm_wr_addr_o;
  logic [17:0] fm_wr_data_o;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [15:0] evt_coord_o;
  logic        evt_channel_o;

  int total = 0;
  int bad   = 0;

  snn_spike_emitter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fm_rd_en_o   (fm_rd_en_o),
    .fm_rd_addr_o (fm_rd_addr_o),
    .fm_rd_data_i (fm_rd_data_i),
    .fm_wr_en_o   (fm_wr_en_o),
    .fm_wr_addr_o (fm_wr_addr_o),
    .fm_wr_data_o (fm_wr_data_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_coord_o  (evt_coord_o),
    .evt_channel_o(evt_channel_o)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [1024];
  always @(posedge clk) if (fm_rd_en_o) fm_rd_data_i <= mem[fm_rd_addr_o];

  int          n_ev = 0;
  int          n_wr = 0;
  logic [15:0] ev_coord [16];
  logic        ev_ch [16];
  logic [9:0]  wr_addr_log [16];
  logic [17:0] wr_data_log [16];

  always @(posedge clk) begin
    if (rst_n && evt_valid_o && evt_ready_i) begin
      ev_coord[n_ev % 16] <= evt_coord_o;
      ev_ch[n_ev % 16]    <= evt_channel_o;
      n_ev                <= n_ev + 1;
    end
    if (rst_n && fm_wr_en_o) begin
      wr_addr_log[n_wr % 16] <= fm_wr_addr_o;
      wr_data_log[n_wr % 16] <= fm_wr_data_o;
      n_wr                   <= n_wr + 1;
    end
  end

  function automatic logic [17:0] word(input logic [8:0] c1, input logic [8:0] c0);
    return {c1, c0};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_o && cyc < 5000);
    to = !done_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    evt_ready_i = 1'b1;
    #12;
    total++; if ({busy_o, done_o, fm_rd_en_o, fm_wr_en_o, evt_valid_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b exp 00000", {busy_o, done_o, fm_rd_en_o, fm_wr_en_o, evt_valid_o});
    end
    total++; if ({fm_rd_addr_o, fm_wr_addr_o, fm_wr_data_o, evt_coord_o, evt_channel_o} !== '0) begin
      bad++; $display("FAIL reset_data: got nonzero bus %h", {fm_rd_addr_o, fm_wr_addr_o, fm_wr_data_o, evt_coord_o, evt_channel_o});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy got %b exp 0", busy_o);
    end
  endtask

  task automatic test_all_zero();
    int cyc; bit to; int e0; int w0;
    clear_mem();
    e0 = n_ev; w0 = n_wr;
    do_start();
    wait_done(cyc, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout: got no done exp done"); end
    total++; if (cyc !== 2049) begin bad++; $display("FAIL zero_latency: got %0d exp 2049", cyc); end
    total++; if (n_ev - e0 !== 0) begin bad++; $display("FAIL zero_events: got %0d exp 0", n_ev - e0); end
    total++; if (n_wr - w0 !== 0) begin bad++; $display("FAIL zero_writes: got %0d exp 0", n_wr - w0); end
    @(negedge clk);
    total++; if ({busy_o, done_o} !== 2'b00) begin
      bad++; $display("FAIL zero_after_done: got %b exp 00", {busy_o, done_o});
    end
  endtask

  task automatic test_single_fire();
    int cyc; bit to; int e0; int w0;
    clear_mem();
    mem[163] = word(9'd10, 9'd64);
    e0 = n_ev; w0 = n_wr;
    do_start();
    wait_done(cyc, to);
    total++; if (to || cyc !== 2050) begin bad++; $display("FAIL single_latency: got %0d exp 2050", cyc); end
    total++; if (n_ev - e0 !== 1) begin bad++; $display("FAIL single_events: got %0d exp 1", n_ev - e0); end
    total++; if (ev_coord[e0 % 16] !== 16'h0305) begin bad++; $display("FAIL single_coord: got %h exp 0305", ev_coord[e0 % 16]); end
    total++; if (ev_ch[e0 % 16] !== 1'b0) begin bad++; $display("FAIL single_channel: got %b exp 0", ev_ch[e0 % 16]); end
    total++; if (n_wr - w0 !== 1) begin bad++; $display("FAIL single_writes: got %0d exp 1", n_wr - w0); end
    total++; if (wr_addr_log[w0 % 16] !== 10'd163) begin bad++; $display("FAIL single_wr_addr: got %0d exp 163", wr_addr_log[w0 % 16]); end
    total++; if (wr_data_log[w0 % 16] !== word(9'd10, 9'd0)) begin
      bad++; $display("FAIL single_wr_data: got %h exp %h", wr_data_log[w0 % 16], word(9'd10, 9'd0));
    end
  endtask

  task automatic test_stall();
    int cyc; bit to; int e0; int w0; int n;
    clear_mem();
    mem[71] = word(9'd255, 9'd100);
    e0 = n_ev; w0 = n_wr;
    evt_ready_i = 1'b0;
    do_start();
    n = 0;
    while (!evt_valid_o && n < 5000) begin @(negedge clk); n++; end
    total++; if (!evt_valid_o) begin bad++; $display("FAIL stall_valid_timeout: got 0 exp 1"); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({evt_valid_o, evt_coord_o, evt_channel_o} !== {1'b1, 16'h0702, 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b c=%h ch=%b exp v=1 c=0702 ch=0", i, evt_valid_o, evt_coord_o, evt_channel_o);
      end
      if (i < 4) @(negedge clk);
    end
    evt_ready_i = 1'b1;
    @(negedge clk);
    total++; if ({evt_valid_o, evt_coord_o, evt_channel_o} !== {1'b1, 16'h0702, 1'b1}) begin
      bad++; $display("FAIL stall_second: got v=%b c=%h ch=%b exp v=1 c=0702 ch=1", evt_valid_o, evt_coord_o, evt_channel_o);
    end
    wait_done(cyc, to);
    total++; if (to) begin bad++; $display("FAIL stall_timeout: got no done exp done"); end
    total++; if (n_ev - e0 !== 2) begin bad++; $display("FAIL stall_events: got %0d exp 2", n_ev - e0); end
    total++; if ({ev_ch[e0 % 16], ev_ch[(e0 + 1) % 16]} !== 2'b01) begin
      bad++; $display("FAIL stall_order: got %b%b exp 01", ev_ch[e0 % 16], ev_ch[(e0 + 1) % 16]);
    end
    total++; if (ev_coord[(e0 + 1) % 16] !== 16'h0702) begin bad++; $display("FAIL stall_coord2: got %h exp 0702", ev_coord[(e0 + 1) % 16]); end
    total++; if (n_wr - w0 !== 1 || wr_addr_log[w0 % 16] !== 10'd71 || wr_data_log[w0 % 16] !== 18'h0) begin
      bad++; $display("FAIL stall_write: got n=%0d a=%0d d=%h exp n=1 a=71 d=0", n_wr - w0, wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
  endtask

  task automatic test_threshold_edges();
    int cyc; bit to; int e0; int w0;
    clear_mem();
    mem[0] = word(9'h100, 9'h100);
    mem[1] = word(9'h03F, 9'h03F);
    mem[2] = word(9'h1FF, 9'h1FF);
    mem[3] = word(9'h040, 9'h1FF);
    mem[4] = word(9'h03F, 9'h100);
    e0 = n_ev; w0 = n_wr;
    do_start();
    wait_done(cyc, to);
    total++; if (to || cyc !== 2050) begin bad++; $display("FAIL thr_latency: got %0d exp 2050", cyc); end
    total++; if (n_ev - e0 !== 1) begin bad++; $display("FAIL thr_events: got %0d exp 1", n_ev - e0); end
    total++; if ({ev_coord[e0 % 16], ev_ch[e0 % 16]} !== {16'h0300, 1'b1}) begin
      bad++; $display("FAIL thr_event: got c=%h ch=%b exp c=0300 ch=1", ev_coord[e0 % 16], ev_ch[e0 % 16]);
    end
    total++; if (n_wr - w0 !== 1 || wr_addr_log[w0 % 16] !== 10'd3 || wr_data_log[w0 % 16] !== word(9'h000, 9'h1FF)) begin
      bad++; $display("FAIL thr_write: got n=%0d a=%0d d=%h exp n=1 a=3 d=001ff", n_wr - w0, wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
  endtask

  task automatic test_last_pixel();
    int cyc; int xfer; int e0; int w0;
    clear_mem();
    mem[1023] = word(9'd70, 9'd0);
    e0 = n_ev; w0 = n_wr;
    do_start();
    cyc = 0; xfer = -1;
    do begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == 100);
      if (cyc == 101) begin
        total++; if ({busy_o, fm_rd_en_o, fm_rd_addr_o} !== {1'b1, 1'b1, 10'd50}) begin
          bad++; $display("FAIL restart_ignored: got b=%b r=%b a=%0d exp b=1 r=1 a=50", busy_o, fm_rd_en_o, fm_rd_addr_o);
        end
      end
      if (evt_valid_o && evt_ready_i) xfer = cyc;
    end while (!done_o && cyc < 5000);
    total++; if (!done_o || cyc !== 2050) begin bad++; $display("FAIL last_latency: got %0d exp 2050", cyc); end
    total++; if (xfer !== 2049) begin bad++; $display("FAIL last_xfer_cycle: got %0d exp 2049", xfer); end
    total++; if (n_ev - e0 !== 1 || {ev_coord[e0 % 16], ev_ch[e0 % 16]} !== {16'h1F1F, 1'b1}) begin
      bad++; $display("FAIL last_event: got n=%0d c=%h ch=%b exp n=1 c=1f1f ch=1", n_ev - e0, ev_coord[e0 % 16], ev_ch[e0 % 16]);
    end
    total++; if (n_wr - w0 !== 1 || wr_addr_log[w0 % 16] !== 10'd1023 || wr_data_log[w0 % 16] !== 18'h0) begin
      bad++; $display("FAIL last_write: got n=%0d a=%0d d=%h exp n=1 a=1023 d=0", n_wr - w0, wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    total++; if ({busy_o, done_o} !== 2'b00) begin
      bad++; $display("FAIL start_at_done: got %b exp 00", {busy_o, done_o});
    end
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL start_at_done_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; int e0; int n;
    clear_mem();
    mem[5] = word(9'd0, 9'd80);
    evt_ready_i = 1'b0;
    do_start();
    n = 0;
    while (!evt_valid_o && n < 5000) begin @(negedge clk); n++; end
    total++; if (!evt_valid_o) begin bad++; $display("FAIL rst_valid_timeout: got 0 exp 1"); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({evt_valid_o, busy_o, fm_wr_en_o, fm_rd_en_o, done_o} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_drop: got %b exp 00000", {evt_valid_o, busy_o, fm_wr_en_o, fm_rd_en_o, done_o});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: got %b exp 0", busy_o); end
    evt_ready_i = 1'b1;
    e0 = n_ev;
    do_start();
    @(negedge clk);
    total++; if ({fm_rd_en_o, fm_rd_addr_o} !== {1'b1, 10'd0}) begin
      bad++; $display("FAIL rst_rescan_addr: got r=%b a=%0d exp r=1 a=0", fm_rd_en_o, fm_rd_addr_o);
    end
    wait_done(cyc, to);
    total++; if (to || n_ev - e0 !== 1 || {ev_coord[e0 % 16], ev_ch[e0 % 16]} !== {16'h0500, 1'b0}) begin
      bad++; $display("FAIL rst_rescan_event: got n=%0d c=%h ch=%b exp n=1 c=0500 ch=0", n_ev - e0, ev_coord[e0 % 16], ev_ch[e0 % 16]);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_fire();
    test_stall();
    test_threshold_edges();
    test_last_pixel();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
